// File: rtl/alu_mux_controller_pkg.sv
// Shared types and widths for the ALU result-multiplexer sequencing controller.
package alu_mux_controller_pkg;

  localparam int unsigned SelW     = 2;
  localparam int unsigned MW       = 4;
  localparam int unsigned NumCodes = 1 << SelW;
  localparam int unsigned ResW     = MW * NumCodes;
  localparam int unsigned CntW     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StRespond
  } state_e;

endpackage

// File: rtl/alu_mux_controller.sv
// Steps the multiplexer select through one code or a full sweep, waits a settle window per
// code, captures the returned nibble and hands the packed result out over valid/ready.
module alu_mux_controller
  import alu_mux_controller_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic            reqSweep,
  input  logic [SelW-1:0] reqSel,
  output logic [SelW-1:0] selMUX,
  input  logic [MW-1:0]   M,
  output logic            resValid,
  input  logic            resReady,
  output logic [ResW-1:0] result,
  output logic [NumCodes-1:0] resMask
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);
  localparam logic [SelW-1:0] SelLast = '1;

  state_e                state_q, state_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  sweep_q, sweep_d;
  logic [ResW-1:0]       result_q, result_d;
  logic [NumCodes-1:0]   mask_q, mask_d;
  logic                  res_valid_q, res_valid_d;
  logic                  req_ready_q, req_ready_d;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    sweep_d     = sweep_q;
    result_d    = result_q;
    mask_d      = mask_q;
    res_valid_d = res_valid_q;
    req_ready_d = req_ready_q;
    unique case (state_q)
      StIdle: begin
        if (reqValid) begin
          state_d     = StDrive;
          sel_d       = reqSweep ? '0 : reqSel;
          sweep_d     = reqSweep;
          result_d    = '0;
          mask_d      = '0;
          cnt_d       = CntInit;
          req_ready_d = 1'b0;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          result_d[{sel_q, 2'b00} +: MW] = M;
          mask_d[sel_q]                  = 1'b1;
          // Sweeps stop at the last code rather than wrapping.
          if (sweep_q && sel_q != SelLast) begin
            sel_d = sel_q + 2'd1;
            cnt_d = CntInit;
          end else begin
            state_d     = StRespond;
            res_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRespond: begin
        if (resReady) begin
          state_d     = StIdle;
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        res_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cnt_q       <= '0;
      sweep_q     <= 1'b0;
      result_q    <= '0;
      mask_q      <= '0;
      res_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      sweep_q     <= sweep_d;
      result_q    <= result_d;
      mask_q      <= mask_d;
      res_valid_q <= res_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign reqReady = req_ready_q;
  assign resValid = res_valid_q;
  assign selMUX   = sel_q;
  assign result   = result_q;
  assign resMask  = mask_q;

endmodule

// File: tb/tb_alu_mux_controller.sv
// Bench for alu_mux_controller: two instances (settle 1 and 3) driven by table vectors,
// random transactions and hand-written reset / back-to-back sequences.
module tb_alu_mux_controller;

  logic        clk;
  logic        rst;
  logic        rv    [2];
  logic        rr    [2];
  logic        rsw   [2];
  logic [1:0]  rsel  [2];
  logic [1:0]  sel   [2];
  logic [3:0]  mm    [2];
  logic        rvld  [2];
  logic        rrdy  [2];
  logic [15:0] res   [2];
  logic [3:0]  mask  [2];
  logic [15:0] m_tab [2];

  int checks   = 0;
  int failures = 0;

  assign mm[0] = m_tab[0][{sel[0], 2'b00} +: 4];
  assign mm[1] = m_tab[1][{sel[1], 2'b00} +: 4];

  alu_mux_controller #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst), .reqValid(rv[0]), .reqReady(rr[0]), .reqSweep(rsw[0]),
    .reqSel(rsel[0]), .selMUX(sel[0]), .M(mm[0]), .resValid(rvld[0]), .resReady(rrdy[0]),
    .result(res[0]), .resMask(mask[0])
  );

  alu_mux_controller #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst(rst), .reqValid(rv[1]), .reqReady(rr[1]), .reqSweep(rsw[1]),
    .reqSel(rsel[1]), .selMUX(sel[1]), .M(mm[1]), .resValid(rvld[1]), .resReady(rrdy[1]),
    .result(res[1]), .resMask(mask[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          sweep;
    logic [1:0]  sel;
    logic [15:0] tab;
    int          hold;
    logic [15:0] exp_res;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Codes captured so far: a sweep fills 0..ncap-1, a single request fills only its code.
  function automatic logic [3:0] model_mask(input bit sweep, input logic [1:0] s, input int ncap);
    int v;
    if (sweep) v = (1 << ncap) - 1;
    else       v = (ncap >= 1) ? (1 << s) : 0;
    return v[3:0];
  endfunction

  function automatic logic [15:0] model_result(input logic [15:0] tab, input logic [3:0] msk);
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) if (msk[c]) r[c*4 +: 4] = tab[c*4 +: 4];
    return r;
  endfunction

  // Starts just after a negedge with the instance idle; ends just after a negedge, idle again.
  task automatic run_txn(input int idx, input bit sweep, input logic [1:0] s, input int hold,
                         output logic [15:0] got_res, output logic [3:0] got_mask);
    int          st, n, ncap;
    logic [1:0]  last;
    logic [3:0]  emask;
    logic [15:0] eres;
    st = (idx == 0) ? 1 : 3;
    n  = sweep ? 4 : 1;
    check("req_ready before accept", 32'(rr[idx]), 32'd1);
    rv[idx] = 1'b1; rsw[idx] = sweep; rsel[idx] = s;
    @(posedge clk);
    @(negedge clk);
    rv[idx] = 1'b0; rsw[idx] = 1'($urandom); rsel[idx] = 2'($urandom);
    for (int t = 1; t <= st * n; t++) begin
      ncap = (t - 1) / st;
      check("sel while driving", 32'(sel[idx]), sweep ? 32'(ncap) : 32'(s));
      check("mask while driving", 32'(mask[idx]), 32'(model_mask(sweep, s, ncap)));
      check("res_valid while driving", 32'(rvld[idx]), 32'd0);
      check("req_ready while driving", 32'(rr[idx]), 32'd0);
      @(negedge clk);
    end
    last  = sweep ? 2'd3 : s;
    emask = model_mask(sweep, s, n);
    eres  = model_result(m_tab[idx], emask);
    for (int h = 0; h < hold; h++) begin
      check("res_valid held", 32'(rvld[idx]), 32'd1);
      check("result held", 32'(res[idx]), 32'(eres));
      check("mask held", 32'(mask[idx]), 32'(emask));
      check("req_ready in respond", 32'(rr[idx]), 32'd0);
      check("sel in respond", 32'(sel[idx]), 32'(last));
      rv[idx] = (h == 1);
      @(negedge clk);
    end
    rv[idx] = 1'b0;
    check("res_valid at handoff", 32'(rvld[idx]), 32'd1);
    check("result at handoff", 32'(res[idx]), 32'(eres));
    check("mask at handoff", 32'(mask[idx]), 32'(emask));
    got_res  = res[idx];
    got_mask = mask[idx];
    rrdy[idx] = 1'b1;
    @(negedge clk);
    rrdy[idx] = 1'b0;
    check("res_valid after handoff", 32'(rvld[idx]), 32'd0);
    check("req_ready after handoff", 32'(rr[idx]), 32'd1);
    check("sel kept in idle", 32'(sel[idx]), 32'(last));
  endtask

  initial begin
    logic [15:0] gr;
    logic [3:0]  gm;
    int          accepts, last_acc, cyc;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rsw[i] = 0; rsel[i] = 0; rrdy[i] = 0; m_tab[i] = 16'h0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset sel", 32'(sel[i]), 32'd0);
      check("reset result", 32'(res[i]), 32'd0);
      check("reset mask", 32'(mask[i]), 32'd0);
      check("reset res_valid", 32'(rvld[i]), 32'd0);
      check("reset req_ready", 32'(rr[i]), 32'd1);
    end

    vecs[0] = '{idx: 0, sweep: 0, sel: 2'd2, tab: 16'h8765, hold: 0,
                exp_res: 16'h0700, exp_mask: 4'b0100};
    vecs[1] = '{idx: 1, sweep: 1, sel: 2'd2, tab: 16'hCDEF, hold: 0,
                exp_res: 16'hCDEF, exp_mask: 4'hF};
    vecs[2] = '{idx: 0, sweep: 0, sel: 2'd3, tab: 16'h8765, hold: 5,
                exp_res: 16'h8000, exp_mask: 4'b1000};
    vecs[3] = '{idx: 0, sweep: 1, sel: 2'd1, tab: 16'h1234, hold: 2,
                exp_res: 16'h1234, exp_mask: 4'hF};
    vecs[4] = '{idx: 1, sweep: 0, sel: 2'd0, tab: 16'hA5C3, hold: 3,
                exp_res: 16'h0003, exp_mask: 4'b0001};
    for (int v = 0; v < 5; v++) begin
      m_tab[vecs[v].idx] = vecs[v].tab;
      run_txn(vecs[v].idx, vecs[v].sweep, vecs[v].sel, vecs[v].hold, gr, gm);
      check("vector result", 32'(gr), 32'(vecs[v].exp_res));
      check("vector mask", 32'(gm), 32'(vecs[v].exp_mask));
    end

    for (int k = 0; k < 20; k++) begin
      int i;
      i = int'($urandom_range(1, 0));
      m_tab[i] = 16'($urandom);
      run_txn(i, 1'($urandom), 2'($urandom), int'($urandom_range(3, 0)), gr, gm);
    end

    // Reset during the second sweep step of the settle-3 instance.
    m_tab[1] = 16'($urandom);
    rv[1] = 1'b1; rsw[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv[1] = 1'b0; rsw[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("sel in second step", 32'(sel[1]), 32'd1);
    check("mask in second step", 32'(mask[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort sel", 32'(sel[1]), 32'd0);
    check("abort result", 32'(res[1]), 32'd0);
    check("abort mask", 32'(mask[1]), 32'd0);
    check("abort res_valid", 32'(rvld[1]), 32'd0);
    check("abort req_ready", 32'(rr[1]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_tab[1] = 16'h9ABC;
    run_txn(1, 1'b0, 2'd1, 1, gr, gm);
    check("post-abort mask", 32'(gm), 32'b0010);
    check("post-abort result", 32'(gr), 32'h00B0);

    // Back-to-back single requests with both handshakes tied high.
    m_tab[0] = 16'h4321;
    rsw[0] = 1'b0; rsel[0] = 2'd2; rv[0] = 1'b1; rrdy[0] = 1'b1;
    accepts = 0; last_acc = -1;
    for (cyc = 0; cyc < 16; cyc++) begin
      check("no accept on handoff", 32'(rr[0] & rvld[0]), 32'd0);
      if (rvld[0]) check("b2b result", 32'(res[0]), 32'h0300);
      if (rr[0]) begin
        if (last_acc >= 0) check("accept spacing", 32'(cyc - last_acc), 32'd3);
        last_acc = cyc;
        accepts++;
      end
      @(negedge clk);
    end
    check("b2b accept count", 32'(accepts), 32'd6);
    rv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rrdy[0] = 1'b0;
    check("b2b drained", 32'(rr[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
